// File: rtl/if_prefetch_buf.sv
// Instruction-fetch prefetch buffer: streams sequential ROM words into a small FIFO ahead of decode.
// Optional same-cycle bypass from ROM to decode when the FIFO is empty: define IF_PREFETCH_BYPASS_EN.
module if_prefetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr_o,
   output logic        rom_ce_o,
   input  logic [31:0] rom_data_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o
);

   localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW         = AW + 1;
   localparam logic [CW-1:0] L_FULL     = CW'(DEPTH);
   localparam logic [CW-1:0] L_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] L_CNT_ZERO = CW'(0);
   localparam logic [AW-1:0] L_PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] L_PTR_ZERO = AW'(0);

   logic [31:0]   r_fetch_pc;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [63:0]   r_mem [DEPTH];   // each entry is {pc, instruction}

   logic          w_empty;
   logic          w_ce;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic [63:0]   w_head;
   logic [31:0]   w_flush_pc;

   // Fetch/push/pop qualification; flush and reset suppress all traffic.
   always_comb begin
      w_empty    = (r_count == L_CNT_ZERO);
      w_ce       = !rst && (r_count < L_FULL) && !flush_i;
      w_head     = r_mem[r_rptr];
      w_flush_pc = flush_pc_i & 32'hFFFF_FFFC;
`ifdef IF_PREFETCH_BYPASS_EN
      w_bypass   = w_empty && w_ce;
`else
      w_bypass   = 1'b0;
`endif
      // A bypassed word taken by decode this cycle never enters the FIFO.
      w_push     = w_ce && !(w_bypass && inst_ready_i);
      w_pop      = !rst && !flush_i && !w_empty && inst_ready_i;
   end

   // Decode-side and ROM-side outputs.
   always_comb begin
      rom_ce_o = w_ce;
      if (rst) begin
         rom_addr_o   = RESET_PC;
         inst_valid_o = 1'b0;
         inst_o       = 32'h0000_0000;
         inst_pc_o    = 32'h0000_0000;
      end else if (w_bypass) begin
         rom_addr_o   = r_fetch_pc;
         inst_valid_o = 1'b1;
         inst_o       = rom_data_i;
         inst_pc_o    = r_fetch_pc;
      end else begin
         rom_addr_o   = r_fetch_pc;
         inst_valid_o = !w_empty && !flush_i;
         inst_o       = w_head[31:0];
         inst_pc_o    = w_head[63:32];
      end
   end

   // Fetch PC, FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_wptr     <= L_PTR_ZERO;
         r_rptr     <= L_PTR_ZERO;
         r_count    <= L_CNT_ZERO;
      end else if (flush_i) begin
         r_fetch_pc <= w_flush_pc;
         r_wptr     <= L_PTR_ZERO;
         r_rptr     <= L_PTR_ZERO;
         r_count    <= L_CNT_ZERO;
      end else begin
         if (w_ce) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_wptr <= r_wptr + L_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + L_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + L_CNT_ONE;
            2'b01:   r_count <= r_count - L_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {r_fetch_pc, rom_data_i};
      end
   end

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Self-checking bench for if_prefetch_buf: a reference fetch model pushes expected PCs to a
// scoreboard queue as fetches occur; deliveries pop and compare pc/inst against the ROM pattern.
module tb_if_prefetch_buf;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rom_addr_o;
   logic        rom_ce_o;
   logic [31:0] rom_data_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model_pc;

   always #5 clk = ~clk;

   // ROM word n at byte address 4n holds 0x13 + n.
   assign rom_data_i = 32'h0000_0013 + {2'b00, rom_addr_o[31:2]};

   if_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .rom_addr_o   (rom_addr_o),
      .rom_ce_o     (rom_ce_o),
      .rom_data_i   (rom_data_i),
      .flush_i      (flush_i),
      .flush_pc_i   (flush_pc_i),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock: check outputs at negedge, advance the reference model, then move past the posedge.
   task automatic step();
      logic        exp_ce;
      logic        exp_valid;
      logic [31:0] pc;
      @(negedge clk);
      if (rst) begin
         check_val("rst_ce",    {31'd0, rom_ce_o},     32'd0);
         check_val("rst_valid", {31'd0, inst_valid_o}, 32'd0);
         check_val("rst_inst",  inst_o,                32'd0);
         check_val("rst_pc",    inst_pc_o,             32'd0);
         check_val("rst_addr",  rom_addr_o,            RESET_PC);
         exp_q.delete();
         model_pc = RESET_PC;
      end else if (flush_i) begin
         check_val("flush_ce",    {31'd0, rom_ce_o},     32'd0);
         check_val("flush_valid", {31'd0, inst_valid_o}, 32'd0);
         check_val("flush_addr",  rom_addr_o,            model_pc);
         exp_q.delete();
         model_pc = flush_pc_i & 32'hFFFF_FFFC;
      end else begin
         exp_ce = (exp_q.size() < DEPTH);
`ifdef IF_PREFETCH_BYPASS_EN
         exp_valid = (exp_q.size() != 0) || exp_ce;
`else
         exp_valid = (exp_q.size() != 0);
`endif
         check_val("addr",  rom_addr_o,            model_pc);
         check_val("ce",    {31'd0, rom_ce_o},     {31'd0, exp_ce});
         check_val("valid", {31'd0, inst_valid_o}, {31'd0, exp_valid});
         if (exp_ce) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
         end
         if (exp_valid && inst_ready_i) begin
            pc = exp_q.pop_front();
            check_val("inst_pc", inst_pc_o, pc);
            check_val("inst",    inst_o,    32'h0000_0013 + {2'b00, pc[31:2]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
      end
   endtask

   initial begin
      rst          = 1'b1;
      flush_i      = 1'b0;
      flush_pc_i   = 32'h0000_0000;
      inst_ready_i = 1'b0;
      model_pc     = RESET_PC;
      run(2);

      // Straight-line streaming with decode always ready.
      rst          = 1'b0;
      inst_ready_i = 1'b1;
      run(8);

      // Fill to full with decode stalled, then drain.
      rst = 1'b1;
      run(1);
      rst          = 1'b0;
      inst_ready_i = 1'b0;
      run(10);
      inst_ready_i = 1'b1;
      run(8);

      // Flush with three buffered entries to an unaligned target.
      rst = 1'b1;
      run(1);
      rst          = 1'b0;
      inst_ready_i = 1'b0;
      run(3);
      flush_i    = 1'b1;
      flush_pc_i = 32'h0000_0203;
      run(1);
      flush_i      = 1'b0;
      inst_ready_i = 1'b1;
      run(6);

      // Fetch PC wrap through the top of the address space.
      flush_i    = 1'b1;
      flush_pc_i = 32'hFFFF_FFF8;
      run(1);
      flush_i = 1'b0;
      run(6);

      // Reset while full: nothing buffered before reset may come out.
      inst_ready_i = 1'b0;
      run(6);
      rst = 1'b1;
      run(1);
      rst          = 1'b0;
      inst_ready_i = 1'b1;
      run(6);

      // Flush held for several cycles with a changing target.
      flush_i    = 1'b1;
      flush_pc_i = 32'h0000_1000;
      run(1);
      flush_pc_i = 32'h0000_2000;
      run(2);
      flush_i = 1'b0;
      run(5);

      // Random backpressure with sporadic flushes.
      for (int i = 0; i < 1000; i++) begin
         inst_ready_i = 1'($urandom_range(0, 1));
         flush_i      = ($urandom_range(0, 39) == 0);
         flush_pc_i   = $urandom;
         step();
      end
      flush_i = 1'b0;
      run(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
